// File: rtl/fsm5_pkg.sv
// Shared encodings for the input conditioner and the downstream 5-state pulse-counting FSM.
package fsm5_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'b00,
    ST_QHI = 2'b01,
    ST_HI  = 2'b10,
    ST_QLO = 2'b11
  } cond_state_t;

  localparam int GLITCH_W = 8;

  typedef enum logic [2:0] {
    s0 = 3'd0,
    s1 = 3'd1,
    s2 = 3'd2,
    s3 = 3'd3,
    s4 = 3'd4
  } fsm5_state_t;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == '1) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/in_pulse_cond_if.sv
// Signal bundle between a raw-input source and in_pulse_cond.
// GLITCH_CNT exists only when IN_COND_GLITCH_CNT_EN is defined.
interface in_pulse_cond_if;
  logic RAW_IN;
  logic EN;
  logic IN_PULSE;
  logic LEVEL;
  logic BUSY;
`ifdef IN_COND_GLITCH_CNT_EN
  logic [fsm5_pkg::GLITCH_W-1:0] GLITCH_CNT;

  modport master (output RAW_IN, EN, input IN_PULSE, LEVEL, BUSY, GLITCH_CNT);
  modport slave  (input RAW_IN, EN, output IN_PULSE, LEVEL, BUSY, GLITCH_CNT);
`else
  modport master (output RAW_IN, EN, input IN_PULSE, LEVEL, BUSY);
  modport slave  (input RAW_IN, EN, output IN_PULSE, LEVEL, BUSY);
`endif
endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous level; q is the last stage.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: flops use non-blocking assignment so every stage samples its predecessor's old value.
  always_ff @(posedge CLK) begin
    if (RST) stages <= '0;
    else     stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/in_pulse_cond.sv
// Synchronise, debounce and edge-detect a raw input into one-cycle IN pulses for FSM5.
// Optional rejected-glitch counter: define IN_COND_GLITCH_CNT_EN.
module in_pulse_cond
  import fsm5_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic           CLK,
  input  logic           RST,
  in_pulse_cond_if.slave io
);

  localparam bit             SINGLE   = (DEBOUNCE_CYCLES == 1);
  localparam int             DC_LAST  = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DC_LAST);

  logic              sync_q;
  cond_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
`ifdef IN_COND_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;
  logic                glitch_inc;
`endif

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (io.RAW_IN),
    .q   (sync_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
`ifdef IN_COND_GLITCH_CNT_EN
      glitch_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
`ifdef IN_COND_GLITCH_CNT_EN
      if (glitch_inc) glitch_q <= sat_inc(glitch_q);
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    pulse_d    = 1'b0;
`ifdef IN_COND_GLITCH_CNT_EN
    glitch_inc = 1'b0;
`endif
    if (!io.EN) begin
      // Disabled: drop any qualification back to the stable state, silently.
      cnt_d   = '0;
      state_d = (state_q == ST_HI || state_q == ST_QLO) ? ST_HI : ST_LO;
    end else begin
      case (state_q)
        ST_LO: if (sync_q) begin
          cnt_d = '0;
          if (SINGLE) begin
            state_d = ST_HI;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_QHI;
          end
        end
        ST_QHI: begin
          if (!sync_q) begin
            state_d = ST_LO;
            cnt_d   = '0;
`ifdef IN_COND_GLITCH_CNT_EN
            glitch_inc = 1'b1;
`endif
          end else if (SINGLE || cnt_q == CNT_LAST) begin
            state_d = ST_HI;
            level_d = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HI: if (!sync_q) begin
          cnt_d = '0;
          if (SINGLE) begin
            state_d = ST_LO;
            level_d = 1'b0;
          end else begin
            state_d = ST_QLO;
          end
        end
        ST_QLO: begin
          if (sync_q) begin
            state_d = ST_HI;
            cnt_d   = '0;
`ifdef IN_COND_GLITCH_CNT_EN
            glitch_inc = 1'b1;
`endif
          end else if (SINGLE || cnt_q == CNT_LAST) begin
            state_d = ST_LO;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign io.IN_PULSE = pulse_q;
  assign io.LEVEL    = level_q;
  assign io.BUSY     = (state_q == ST_QHI) || (state_q == ST_QLO);
`ifdef IN_COND_GLITCH_CNT_EN
  assign io.GLITCH_CNT = glitch_q;
`endif

endmodule
